lcd_cmd_fifo: RTL
=================

Name: lcd_cmd_fifo

Overview:
- Parametrised synchronous command FIFO; the next-generation buffer between the ALU command writer and the slow LCD sequencing FSM.
- Adds the following over the previous buffer:
  - arbitrary power-of-two depth;
  - an exact occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - flush;
  - sticky overflow and underflow error flags;
  - first-word-fall-through read data.
- Usable as a general circular FIFO elsewhere in the design.

Parameters:
- DATA_WIDTH, 10, command word width ({lcd_rs, lcd_rw, sf[7:0]} by default).
- DEPTH, 64, number of entries. Must be a power of two, 2..256.
- AFULL_LVL, DEPTH-4, almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  command word to enqueue.
- wr_en  in  1  write request.
- rd_en  in  1  read request; pops the current head word.
- flush  in  1  synchronous discard of all contents.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  DATA_WIDTH  head-of-queue word (first-word-fall-through); 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_LVL.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a rejected write.
- underflow  out  1  sticky; set by a rejected read.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x DATA_WIDTH register array with log2(DEPTH)-bit wr_ptr and rd_ptr.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count is a separate register, log2(DEPTH)+1 bits wide, so full and empty are unambiguous.
- Reset, in priority over everything:
  - wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0.
  - Outputs after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (when AFULL_LVL > 0), data_out = 0.
  - Memory contents are not cleared.
- Flush, second priority:
  - Pointers and count go to 0 in the same cycle.
  - wr_en and rd_en in that cycle are ignored.
  - Error flags are not raised and are otherwise unchanged.
- Accept rules, evaluated on registered state at the clock edge:
  - rd_ok = rd_en & !empty.
  - wr_ok = wr_en & (!full | rd_ok). A write while full is accepted if a read is accepted in the same cycle.
- Write: when wr_ok, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1.
- Read: when rd_ok, rd_ptr <= rd_ptr+1.
- count update:
  - +1 when wr_ok & !rd_ok.
  - -1 when rd_ok & !wr_ok.
  - Unchanged when both or neither.
- Status flags:
  - data_out = mem[rd_ptr] when !empty, else 0. This is combinational from registered state, so zero read latency.
  - A word written at edge N appears on data_out after edge N (write-to-read latency 1 cycle) when the FIFO was empty.
  - empty, full, almost_empty and almost_full are decoded combinationally from the count register, so they reflect state after the most recent edge.
- Simultaneous read and write:
  - When empty: the write is accepted, the read is rejected, underflow is set, count becomes 1.
  - When 0 < count < DEPTH: both are accepted, count is unchanged, and the written data is not visible until the existing entries drain.
- Error flags:
  - overflow <= 1 when wr_en & !wr_ok & !flush.
  - underflow <= 1 when rd_en & !rd_ok & !flush.
  - Both stay set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
- Rejected operations never modify memory, pointers or count.

Test Plan:
- Basic order: after reset, write 0x001, 0x102, 0x203 on 3 consecutive cycles, then read 3 → data_out shows 0x001 the cycle after the first write; reads return 0x001, 0x102, 0x203 in order; count goes 1, 2, 3, 2, 1, 0; empty = 1 at the end.
- Fill and overflow (DEPTH=64, AFULL_LVL=60): write 0..63 → almost_full first high at count = 60, full = 1 at count = 64. A 65th write of 0x3FF → overflow = 1, count stays 64. Then read all 64 words → values 0..63 in order, no 0x3FF.
- Wrap-around: write 40, read 40, write 40, read 40 with incrementing data → every word matches, pointers cross index 63 → 0 with no loss.
- Simultaneous ops:
  - Full, with wr_en and rd_en together and data_in = 0x155 → count stays 64, head advances, 0x155 is read out last, no overflow.
  - Empty, with wr_en and rd_en together → count = 1, underflow = 1, data_out = written word next cycle.
- Flush and errors: with count = 10, assert flush together with wr_en → count = 0, empty = 1, data_out = 0, no overflow. Then a read while empty → underflow = 1. clr_err → underflow = 0. clr_err together with another empty read → underflow stays 1.
- Reset mid-operation: with count = 5 and overflow = 1, assert reset together with wr_en and rd_en → next cycle count = 0, empty = 1, both error flags = 0, and the write is dropped.

Source files
------------

// File: rtl/lcd_cmd_fifo_if.sv
// rtl/lcd_cmd_fifo_if.sv - write/read/status signal bundle for the LCD command FIFO
interface lcd_cmd_fifo_if #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic                  flush;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output data_in, wr_en, rd_en, flush, clr_err,
      input  data_out, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  data_in, wr_en, rd_en, flush, clr_err,
      output data_out, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous circular command FIFO with exact count and sticky errors
// First-word-fall-through: data_out is the head entry, zero when empty.
module lcd_cmd_fifo #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 64,
   parameter int AFULL_LVL  = DEPTH - 4,
   parameter int AEMPTY_LVL = 2
) (
   input  logic            clk,
   input  logic            reset,
   lcd_cmd_fifo_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic empty;
   logic full;
   logic rd_ok;
   logic wr_ok;
   logic rd_acc;
   logic wr_acc;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);

   // rd_ok/wr_ok decide acceptance for error reporting; *_acc additionally
   // drop the operation when flush or reset takes over the cycle.
   always_comb begin
      rd_ok  = bus.rd_en & ~empty;
      wr_ok  = bus.wr_en & (~full | rd_ok);
      rd_acc = rd_ok & ~bus.flush & ~reset;
      wr_acc = wr_ok & ~bus.flush & ~reset;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_acc & ~rd_acc)
            count_d = count_q + 1'b1;
         else if (rd_acc & ~wr_acc)
            count_d = count_q - 1'b1;
      end
   end

   // Clear first so a coincident new error leaves the flag set.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr_en & ~wr_ok & ~bus.flush) overflow_d  = 1'b1;
      if (bus.rd_en & ~rd_ok & ~bus.flush) underflow_d = 1'b1;
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_acc) mem_d[wr_ptr_q] = bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      bus.data_out     = empty ? '0 : mem_q[rd_ptr_q];
      bus.empty        = empty;
      bus.full         = full;
      bus.almost_empty = (count_q <= AEMPTY_C);
      bus.almost_full  = (count_q >= AFULL_C);
      bus.count        = count_q;
      bus.overflow     = overflow_q;
      bus.underflow    = underflow_q;
   end
endmodule
